cmd_queue_arb: RTL

// Round-robin arbiter sharing the signal generator's single 80-bit command FIFO port among NQ requester queues.

---
 rtl/cmd_queue_arb_pkg.sv | 23 ++
 rtl/cmd_queue_arb_rr_pick.sv | 33 +++
 rtl/cmd_queue_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cmd_queue_arb_pkg.sv
// Shared definitions for the command queue arbiter: command word field
// offsets, the lock FSM state type and the queue-id width helper.
`timescale 1ns/1ps
package cmd_queue_arb_pkg;

    // Field offsets inside the 80-bit command word
    localparam int ADDR_LSB = 0;
    localparam int WAIT_LSB = 32;
    localparam int CTRL_LSB = 64;
    localparam int QSEL_LSB = 72;
    localparam int LOCK_BIT = 71;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_t;

    // Width of a queue index; never narrower than one bit
    function automatic int qid_w(input int nq);
        return (nq > 1) ? $clog2(nq) : 1;
    endfunction

endpackage

// File: rtl/cmd_queue_arb_rr_pick.sv
// Rotate-priority encoder: grants the first requester strictly after the
// pointer, wrapping from NQ-1 back to 0, so the pointer owner is served last.
`timescale 1ns/1ps
module rr_pick #(
    parameter int NQ = 4,
    parameter int IW = 2
) (
    input  logic [NQ-1:0] i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [NQ-1:0] o_gntOnehot,
    output logic [IW-1:0] o_gntIdx,
    output logic          o_any
);

    logic [IW-1:0] w_idx;

    // Scan the requesters in rotated order and keep the first hit
    always_comb begin
        o_gntOnehot = '0;
        o_gntIdx    = '0;
        o_any       = 1'b0;
        w_idx       = '0;
        for (int i = 1; i <= NQ; i++) begin
            w_idx = IW'((int'(i_ptr) + i) % NQ);
            if (!o_any && i_req[w_idx]) begin
                o_any              = 1'b1;
                o_gntIdx           = w_idx;
                o_gntOnehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_queue_arb.sv
// Round-robin arbiter that merges NQ FWFT command queues into one single-entry
// FWFT output buffer, with burst lock (ctrl bit 7), lock timeout, per-queue
// enable mask and a sticky underflow flag.
`timescale 1ns/1ps
module cmd_queue_arb
    import cmd_queue_arb_pkg::*;
#(
    parameter int NQ      = 4,
    parameter int B       = 80,
    parameter int LOCK_TO = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [NQ-1:0]        q_rd_en,
    input  logic [NQ-1:0]        q_empty,
    input  logic [NQ*B-1:0]      q_dout,
    input  logic                 fifo_rd_en,
    output logic                 fifo_empty,
    output logic [B-1:0]         fifo_dout,
    output logic [qid_w(NQ)-1:0] fifo_qid,
    input  logic [NQ-1:0]        QEN_REG,
    output logic                 locked,
    output logic                 err_unf
);

    localparam int IW = qid_w(NQ);
    localparam int CW = $clog2(LOCK_TO + 1);

    arb_state_t    r_state;
    arb_state_t    w_nextState;
    logic          r_valid;
    logic [B-1:0]  r_dout;
    logic [IW-1:0] r_qid;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_nextCnt;
    logic          r_errUnf;

    logic [NQ-1:0] w_elig;
    logic [NQ-1:0] w_lockMask;
    logic [NQ-1:0] w_req;
    logic [NQ-1:0] w_gntOh;
    logic [IW-1:0] w_gntIdx;
    logic          w_any;
    logic          w_canLoad;
    logic          w_load;
    logic          w_pop;
    logic [B-1:0]  w_loadWord;
    logic [7:0]    w_ctrl;
    logic          w_lockBit;

    // While locked the pointer holds the locked queue, so it doubles as L
    assign w_elig     = QEN_REG & ~q_empty;
    assign w_lockMask = {{(NQ-1){1'b0}}, 1'b1} << r_ptr;
    assign w_req      = (r_state == LOCKED) ? (w_elig & w_lockMask) : w_elig;

    rr_pick #(
        .NQ (NQ),
        .IW (IW)
    ) u_pick (
        .i_req       (w_req),
        .i_ptr       (r_ptr),
        .o_gntOnehot (w_gntOh),
        .o_gntIdx    (w_gntIdx),
        .o_any       (w_any)
    );

    assign w_canLoad  = ~r_valid | fifo_rd_en;
    assign w_load     = w_canLoad & w_any & ~rst;
    assign w_pop      = fifo_rd_en & r_valid;
    assign w_loadWord = q_dout[int'(w_gntIdx)*B +: B];
    assign w_ctrl     = w_loadWord[CTRL_LSB +: 8];
    assign w_lockBit  = w_ctrl[LOCK_BIT-CTRL_LSB];

    assign q_rd_en    = w_load ? w_gntOh : '0;
    assign fifo_empty = ~r_valid;
    assign fifo_dout  = r_dout;
    assign fifo_qid   = r_qid;
    assign locked     = (r_state == LOCKED);
    assign err_unf    = r_errUnf;

    // Lock FSM state and timeout counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UNLOCKED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Lock entry on ctrl[7], renewal, release on last word, mask drop or timeout
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            UNLOCKED: begin
                if (w_load && w_lockBit) begin
                    w_nextState = LOCKED;
                    w_nextCnt   = '0;
                end
            end
            LOCKED: begin
                if (!QEN_REG[r_ptr]) begin
                    w_nextState = UNLOCKED;
                end else if (w_load) begin
                    if (w_lockBit) begin
                        w_nextCnt = '0;
                    end else begin
                        w_nextState = UNLOCKED;
                    end
                end else if (w_canLoad) begin
                    if (r_cnt == CW'(LOCK_TO - 1)) begin
                        w_nextState = UNLOCKED;
                    end else begin
                        w_nextCnt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_nextState = UNLOCKED;
        endcase
    end

    // Output buffer, round-robin pointer and sticky underflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_dout   <= '0;
            r_qid    <= '0;
            r_ptr    <= IW'(NQ - 1);
            r_errUnf <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_dout  <= w_loadWord;
                r_qid   <= w_gntIdx;
                r_ptr   <= w_gntIdx;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            if (fifo_rd_en && !r_valid) begin
                r_errUnf <= 1'b1;
            end
        end
    end

endmodule
